uart_tx_arbiter: RTL and testbench



---
 rtl/uart_pkg.sv | 19 +
 rtl/rr_pick.sv | 33 +++
 rtl/uart_tx_arbiter.sv | 140 ++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared encodings and defaults for the uart_tx arbiter and related blocks.
package uart_pkg;

  // Arbiter FSM encodings (2-bit, legacy-compatible)
  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_ISSUE     = 2'd1;
  localparam logic [1:0] ST_WAIT_ACK  = 2'd2;
  localparam logic [1:0] ST_WAIT_DONE = 2'd3;

  localparam int NUM_REQ_DEF     = 4;
  localparam int ACK_TIMEOUT_DEF = 16;

  // One byte as offered by the current owner
  typedef struct packed {
    logic [7:0] data;
    logic       last;
  } tx_byte_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set bit of req searching upward
// from ptr, wrapping at N. Reusable for an rx-side dispatcher.
module rr_pick #(
  parameter  int N  = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  win,
  output logic [IW-1:0] idx,
  output logic          any
);

  logic [IW:0] cand;

  // Walk N candidates starting at ptr; the first requester seen wins
  always_comb begin
    win  = '0;
    idx  = '0;
    any  = 1'b0;
    cand = '0;
    for (int i = 0; i < N; i++) begin
      cand = {1'b0, ptr} + (IW+1)'(i);
      if (cand >= (IW+1)'(N)) cand = cand - (IW+1)'(N);
      if (!any && req[cand[IW-1:0]]) begin
        any                 = 1'b1;
        win[cand[IW-1:0]]   = 1'b1;
        idx                 = cand[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one uart_tx between NUM_REQ packet requesters. Grant is held for a
// whole packet (round-robin at packet granularity) and each byte is walked
// through the uart_tx start_write / write_avl handshake with an ack timeout.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ     = NUM_REQ_DEF,
  parameter int ACK_TIMEOUT = ACK_TIMEOUT_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [NUM_REQ-1:0]   grant,
  output logic                 tx_start_write,
  output logic [7:0]           tx_write_data,
  input  logic                 tx_write_avl,
  output logic                 busy,
  output logic                 pkt_done,
  output logic                 err_timeout
);

  localparam int IW = $clog2(NUM_REQ);

  logic [1:0]         state;
  logic [IW-1:0]      rr_ptr;
  logic [IW-1:0]      own;
  logic [7:0]         ack_ctr;
  logic               last_q;

  logic [NUM_REQ-1:0] pick_win;
  logic [IW-1:0]      pick_idx;
  logic               pick_any;

  logic [IW+2:0]      own_base;
  tx_byte_t           own_byte;
  logic               own_req;
  logic               own_vld;
  logic               xfer;
  logic [IW-1:0]      own_nxt;

  rr_pick #(.N(NUM_REQ)) u_pick (
    .req (req),
    .ptr (rr_ptr),
    .win (pick_win),
    .idx (pick_idx),
    .any (pick_any)
  );

  // Owner view: the selected requester's byte, flags and next rr position
  always_comb begin
    own_base      = {own, 3'b000};
    own_byte.data = req_data[own_base +: 8];
    own_byte.last = req_last[own];
    own_req       = req[own];
    own_vld       = req_valid[own];
    xfer          = (state == ST_ISSUE) && own_req && own_vld && tx_write_avl;
    own_nxt       = (own == IW'(NUM_REQ-1)) ? '0 : own + 1'b1;
  end

  // Only the owner can ever see ready, and only during an accepting ISSUE cycle
  always_comb begin
    req_ready = '0;
    if (xfer) req_ready[own] = 1'b1;
  end

  assign busy = |grant;

  // Arbitration and uart_tx handshake sequencing
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= ST_IDLE;
      grant          <= '0;
      rr_ptr         <= '0;
      own            <= '0;
      tx_start_write <= 1'b0;
      tx_write_data  <= 8'h00;
      pkt_done       <= 1'b0;
      err_timeout    <= 1'b0;
      ack_ctr        <= '0;
      last_q         <= 1'b0;
    end else begin
      tx_start_write <= 1'b0;
      pkt_done       <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (pick_any) begin
            grant <= pick_win;
            own   <= pick_idx;
            state <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (!own_req) begin
            // owner withdrew mid-packet: release without pkt_done
            grant  <= '0;
            rr_ptr <= own_nxt;
            state  <= ST_IDLE;
          end else if (xfer) begin
            tx_write_data  <= own_byte.data;
            tx_start_write <= 1'b1;
            last_q         <= own_byte.last;
            ack_ctr        <= '0;
            state          <= ST_WAIT_ACK;
          end
        end
        ST_WAIT_ACK: begin
          if (!tx_write_avl) begin
            state <= ST_WAIT_DONE;
          end else if (ack_ctr == 8'(ACK_TIMEOUT-1)) begin
            // transmitter never took the byte: drop rest of the packet
            err_timeout <= 1'b1;
            grant       <= '0;
            rr_ptr      <= own_nxt;
            state       <= ST_IDLE;
          end else begin
            ack_ctr <= ack_ctr + 1'b1;
          end
        end
        ST_WAIT_DONE: begin
          if (tx_write_avl) begin
            if (last_q) begin
              pkt_done <= 1'b1;
              grant    <= '0;
              rr_ptr   <= own_nxt;
              state    <= ST_IDLE;
            end else begin
              state <= ST_ISSUE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: a cycle table for one packet, then
// multi-requester sequences against a small uart_tx model.
module tb_uart_tx_arbiter;

  localparam int NR = 4;
  localparam int TO = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic [NR-1:0]     req, req_valid, req_last, req_ready, grant;
  logic [8*NR-1:0]   req_data;
  logic              tx_start_write;
  logic [7:0]        tx_write_data;
  logic              tx_write_avl;
  logic              busy, pkt_done, err_timeout;

  uart_tx_arbiter #(.NUM_REQ(NR), .ACK_TIMEOUT(TO)) dut (
    .clk            (clk),
    .reset          (reset),
    .req            (req),
    .req_data       (req_data),
    .req_valid      (req_valid),
    .req_last       (req_last),
    .req_ready      (req_ready),
    .grant          (grant),
    .tx_start_write (tx_start_write),
    .tx_write_data  (tx_write_data),
    .tx_write_avl   (tx_write_avl),
    .busy           (busy),
    .pkt_done       (pkt_done),
    .err_timeout    (err_timeout)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] rq, vld, lst;
    logic [7:0] d;
    logic       avl;
    logic [3:0] e_g, e_r;
    logic       e_s;
    logic [7:0] e_d;
    logic       e_done;
  } vec_t;

  vec_t tbl [14];

  int total = 0, bad = 0, cyc = 0;
  logic rst_nxt;
  int  m_cnt, hold;
  logic m_stuck, m_seen;
  int  rq_on [NR], rq_cnt [NR], rq_len [NR], rq_drop [NR];
  logic [7:0] slog [$];
  logic [3:0] glog [$];
  logic [3:0] gprev;
  int  done_cnt, viol, t_start, t_err;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] rq_byte(input int i, input int k);
    return 8'(65 + 16*i + k);
  endfunction

  function automatic logic [63:0] pack8();
    logic [63:0] v = '0;
    foreach (slog[i]) v = {v[55:0], slog[i]};
    return v;
  endfunction

  function automatic logic [63:0] pack4();
    logic [63:0] v = '0;
    foreach (glog[i]) v = {v[59:0], glog[i]};
    return v;
  endfunction

  function automatic int any_on();
    int n = 0;
    for (int i = 0; i < NR; i++) n += rq_on[i];
    return n;
  endfunction

  task automatic clr_logs();
    slog.delete(); glog.delete();
    done_cnt = 0; viol = 0; t_start = -1; t_err = -1;
    gprev = grant;
  endtask

  task automatic start_rq(input int i, input int len, input int drop);
    rq_on[i] = 1; rq_cnt[i] = 0; rq_len[i] = len; rq_drop[i] = drop;
  endtask

  // One clock: drive at negedge (uart model + requesters), sample 1ns later
  task automatic tick();
    @(negedge clk);
    reset = rst_nxt;
    if (m_cnt > 0) begin
      m_cnt--;
      if (m_cnt == 0) tx_write_avl = 1'b1;
    end else if (m_seen && !m_stuck) begin
      tx_write_avl = 1'b0;
      m_cnt = hold;
    end
    for (int i = 0; i < NR; i++) begin
      req[i]            = (rq_on[i] != 0);
      req_valid[i]      = (rq_on[i] != 0);
      req_last[i]       = (rq_cnt[i] == rq_len[i] - 1);
      req_data[8*i +: 8] = rq_byte(i, rq_cnt[i]);
    end
    #1;
    cyc++;
    m_seen = tx_start_write;
    if (tx_start_write) begin
      slog.push_back(tx_write_data);
      if (t_start < 0) t_start = cyc;
    end
    if (err_timeout && t_err < 0) t_err = cyc;
    if (pkt_done) done_cnt++;
    if (grant != gprev && grant != 4'h0) glog.push_back(grant);
    gprev = grant;
    if ((req_ready & ~grant) != 4'h0 || $countones(req_ready) > 1) viol++;
    for (int i = 0; i < NR; i++) begin
      if (req_ready[i]) begin
        rq_cnt[i]++;
        if (rq_cnt[i] == rq_len[i] || rq_cnt[i] == rq_drop[i]) rq_on[i] = 0;
      end
    end
  endtask

  task automatic run_idle(input int maxc, input string nm);
    int n = 0;
    do begin
      tick();
      n++;
    end while (!(any_on() == 0 && !busy && tx_write_avl && m_cnt == 0) && n < maxc);
    chk(nm, 64'(n < maxc), 64'd1);
  endtask

  task automatic do_reset(input bit all_on);
    for (int i = 0; i < NR; i++) begin
      rq_on[i] = 0; rq_cnt[i] = 0; rq_len[i] = 1; rq_drop[i] = 0;
    end
    if (all_on) for (int i = 0; i < NR; i++) start_rq(i, 2, 0);
    tx_write_avl = 1'b1; m_cnt = 0; m_seen = 1'b0; m_stuck = 1'b0;
    rst_nxt = 1'b1;
    tick(); tick();
    rst_nxt = 1'b0;
    clr_logs();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    reset = 1'b1; rst_nxt = 1'b1;
    req = '0; req_valid = '0; req_last = '0; req_data = '0;
    tx_write_avl = 1'b1; m_cnt = 0; m_seen = 1'b0; m_stuck = 1'b0; hold = 20;
    gprev = '0;
    for (int i = 0; i < NR; i++) begin
      rq_on[i] = 0; rq_cnt[i] = 0; rq_len[i] = 1; rq_drop[i] = 0;
    end

    //            rq    vld   lst   d      avl  | g     r     s     ed     done
    tbl[0]  = '{4'h1, 4'h1, 4'h0, 8'h41, 1'b1, 4'h0, 4'h0, 1'b0, 8'h00, 1'b0};
    tbl[1]  = '{4'h1, 4'h1, 4'h0, 8'h41, 1'b1, 4'h1, 4'h1, 1'b0, 8'h00, 1'b0};
    tbl[2]  = '{4'h1, 4'h1, 4'h1, 8'h42, 1'b1, 4'h1, 4'h0, 1'b1, 8'h41, 1'b0};
    tbl[3]  = '{4'h1, 4'h1, 4'h1, 8'h42, 1'b0, 4'h1, 4'h0, 1'b0, 8'h41, 1'b0};
    tbl[4]  = '{4'h1, 4'h1, 4'h1, 8'h42, 1'b0, 4'h1, 4'h0, 1'b0, 8'h41, 1'b0};
    tbl[5]  = '{4'h1, 4'h1, 4'h1, 8'h42, 1'b1, 4'h1, 4'h0, 1'b0, 8'h41, 1'b0};
    tbl[6]  = '{4'h1, 4'h0, 4'h1, 8'h42, 1'b1, 4'h1, 4'h0, 1'b0, 8'h41, 1'b0};
    tbl[7]  = '{4'h1, 4'h1, 4'h1, 8'h42, 1'b1, 4'h1, 4'h1, 1'b0, 8'h41, 1'b0};
    tbl[8]  = '{4'h1, 4'h1, 4'h1, 8'h42, 1'b1, 4'h1, 4'h0, 1'b1, 8'h42, 1'b0};
    tbl[9]  = '{4'h0, 4'h0, 4'h0, 8'h42, 1'b0, 4'h1, 4'h0, 1'b0, 8'h42, 1'b0};
    tbl[10] = '{4'h0, 4'h0, 4'h0, 8'h00, 1'b1, 4'h1, 4'h0, 1'b0, 8'h42, 1'b0};
    tbl[11] = '{4'h0, 4'h2, 4'h0, 8'h00, 1'b1, 4'h0, 4'h0, 1'b0, 8'h42, 1'b1};
    tbl[12] = '{4'h0, 4'h2, 4'h0, 8'h00, 1'b1, 4'h0, 4'h0, 1'b0, 8'h42, 1'b0};
    tbl[13] = '{4'h0, 4'h2, 4'h0, 8'h00, 1'b1, 4'h0, 4'h0, 1'b0, 8'h42, 1'b0};

    tick(); tick();
    chk("reset_state", 64'({grant, req_ready, tx_start_write, tx_write_data,
                           pkt_done, err_timeout, busy}), 64'd0);
    rst_nxt = 1'b0;

    // cycle table: one 2-byte packet from requester 0, avl driven directly
    for (int r = 0; r < 14; r++) begin
      @(negedge clk);
      reset        = 1'b0;
      req          = tbl[r].rq;
      req_valid    = tbl[r].vld;
      req_last     = tbl[r].lst;
      req_data     = {24'h0, tbl[r].d};
      tx_write_avl = tbl[r].avl;
      #1;
      chk($sformatf("vec%0d", r),
          64'({grant, req_ready, tx_start_write, tx_write_data, pkt_done, busy, err_timeout}),
          64'({tbl[r].e_g, tbl[r].e_r, tbl[r].e_s, tbl[r].e_d, tbl[r].e_done, |tbl[r].e_g, 1'b0}));
    end

    // 1: single requester, 20-cycle busy uart
    do_reset(1'b0);
    start_rq(0, 2, 0);
    run_idle(200, "t1_bound");
    chk("t1_bytes", pack8(), 64'h4142);
    chk("t1_nstart", 64'(slog.size()), 64'd2);
    chk("t1_done", 64'(done_cnt), 64'd1);
    chk("t1_grant", 64'(grant), 64'd0);

    // 2: all four at reset release, then wrap with req 3 and 0
    do_reset(1'b1);
    run_idle(600, "t2_bound");
    chk("t2_bytes", pack8(), 64'h4142515261627172);
    chk("t2_gseq", pack4(), 64'h1248);
    chk("t2_done", 64'(done_cnt), 64'd4);
    clr_logs();
    start_rq(3, 2, 0);
    start_rq(0, 2, 0);
    run_idle(300, "t2b_bound");
    chk("t2b_bytes", pack8(), 64'h41427172);
    chk("t2b_gseq", pack4(), 64'h18);

    // 3: requester 2 rises while requester 1 is mid-packet
    do_reset(1'b0);
    start_rq(1, 3, 0);
    n = 0;
    while (rq_cnt[1] < 1 && n < 100) begin tick(); n++; end
    chk("t3_first_bound", 64'(n < 100), 64'd1);
    start_rq(2, 1, 0);
    run_idle(400, "t3_bound");
    chk("t3_bytes", pack8(), 64'h51525361);
    chk("t3_gseq", pack4(), 64'h24);
    chk("t3_ready_owner", 64'(viol), 64'd0);

    // 5: owner withdraws after first byte without last
    do_reset(1'b0);
    start_rq(0, 4, 1);
    run_idle(200, "t5_bound");
    chk("t5_bytes", pack8(), 64'h41);
    chk("t5_done", 64'(done_cnt), 64'd0);
    clr_logs();
    start_rq(0, 1, 0);
    start_rq(1, 1, 0);
    run_idle(300, "t5b_bound");
    chk("t5b_bytes", pack8(), 64'h5141);
    chk("t5b_gseq", pack4(), 64'h21);

    // 4: uart never acknowledges the first byte
    do_reset(1'b0);
    m_stuck = 1'b1;
    start_rq(0, 2, 0);
    start_rq(1, 1, 0);
    n = 0;
    while (t_err < 0 && n < 100) begin tick(); n++; end
    chk("t4_err_bound", 64'(n < 100), 64'd1);
    chk("t4_latency", 64'(t_err - t_start), 64'(TO));
    chk("t4_grant", 64'(grant), 64'd0);
    m_stuck = 1'b0;
    rq_on[0] = 0;
    run_idle(200, "t4_bound");
    chk("t4_bytes", pack8(), 64'h4151);
    chk("t4_gseq", pack4(), 64'h12);
    chk("t4_sticky", 64'(err_timeout), 64'd1);

    // 6: reset while in WAIT_DONE (err_timeout still set from above)
    start_rq(2, 2, 0);
    n = 0;
    while (!(tx_write_avl == 1'b0 && busy) && n < 100) begin tick(); n++; end
    chk("t6_wait_bound", 64'(n < 100), 64'd1);
    tick();
    rst_nxt = 1'b1;
    start_rq(0, 2, 0);
    rq_cnt[2] = 0;
    tick();
    rst_nxt = 1'b0;
    clr_logs();
    tick();
    chk("t6_reset_vals", 64'({grant, req_ready, tx_start_write, tx_write_data,
                             pkt_done, err_timeout, busy}), 64'd0);
    run_idle(300, "t6_bound");
    chk("t6_bytes", pack8(), 64'h41426162);
    chk("t6_gseq", pack4(), 64'h14);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
